// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
// ----------------
// Sits after the PS/2 receiver. It takes one Set-2 scan-code byte per
// strobe and folds the prefix sequences into single key events:
//   E0 xx        extended make      -> {ext=1, brk=0, code}
//   F0 xx        break              -> {ext=0, brk=1, code}
//   E0 F0 xx     extended break     -> {ext=1, brk=1, code}
//   E1 + 7 bytes Pause              -> {ext=0, brk=0, 8'hE1}
// Finished events go into a small FIFO that the consumer pops.
// A byte flagged with a receiver error is thrown away, and any prefix
// sequence that was in progress is abandoned.
//
// Optional build macro:
//   PS2_DEC_TYPEMATIC_FILTER_EN - when defined, a make event that repeats
//   the most recent make (typematic auto-repeat) is not queued. The held
//   value is forgotten on the matching break, on an error byte and on rst.
//   Pause events are never filtered.
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset
//   byte_in    received scan-code byte, sampled when byte_valid=1
//   byte_valid one-cycle strobe marking byte_in as new
//   byte_err   receiver parity/stop error, qualified by byte_valid
//   ev_data    head event {ext, brk, code}; zero while the FIFO is empty
//   ev_valid   FIFO is non-empty
//   ev_ready   consumer pop, only acts while ev_valid=1
//   ev_count   number of queued events
//   overflow   sticky flag: an event was dropped because the FIFO was full
//
// Parameter:
//   DEPTH      event FIFO depth, power of two, at least 2

module ps2_scan_decoder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     byte_err,
  output logic [9:0]               ev_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE = 8'hE1;

  // The Pause sequence is E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  skip;
  logic [2:0]  next_skip;

  logic        emit;
  logic        emit_ext;
  logic        emit_brk;
  logic [7:0]  emit_code;
  logic        push_req;

  logic        good_byte;
  logic        err_byte;

  assign good_byte = byte_valid & ~byte_err;
  assign err_byte  = byte_valid &  byte_err;

  // ---------------------------------------------------------------------
  // Decoder state register and Pause skip counter.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      skip  <= '0;
    end else begin
      state <= next_state;
      skip  <= next_skip;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and event decode. Only strobed bytes move the FSM.
  // IDLE, BRK and EXT_BRK share one branch: in BRK/EXT_BRK a prefix byte
  // restarts the sequence exactly as it would from IDLE, and a plain byte
  // completes an event whose flags depend on which of the three we are in.
  // In EXT a second E0 is absorbed and every non-F0 byte completes an
  // extended make, including E1.
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    next_skip  = skip;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    emit_code  = byte_in;

    if (err_byte) begin
      next_state = S_IDLE;
      next_skip  = '0;
    end else if (good_byte) begin
      unique case (state)
        S_IDLE, S_BRK, S_EXT_BRK: begin
          if (byte_in == BYTE_EXT) begin
            next_state = S_EXT;
          end else if (byte_in == BYTE_BRK) begin
            next_state = S_BRK;
          end else if (byte_in == BYTE_PAUSE) begin
            next_state = S_PAUSE;
            next_skip  = PAUSE_TAIL;
          end else begin
            emit       = 1'b1;
            emit_ext   = (state == S_EXT_BRK);
            emit_brk   = (state != S_IDLE);
            next_state = S_IDLE;
          end
        end

        S_EXT: begin
          if (byte_in == BYTE_BRK) begin
            next_state = S_EXT_BRK;
          end else if (byte_in == BYTE_EXT) begin
            next_state = S_EXT;
          end else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            next_state = S_IDLE;
          end
        end

        S_PAUSE: begin
          // Tail bytes are counted, never interpreted.
          next_skip = skip - 3'd1;
          if (skip == 3'd1) begin
            emit       = 1'b1;
            emit_code  = BYTE_PAUSE;
            next_state = S_IDLE;
          end
        end

        default: begin
          next_state = S_IDLE;
          next_skip  = '0;
        end
      endcase
    end
  end

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
  // ---------------------------------------------------------------------
  // Typematic filter. last_make holds {ext, code} of the latest make.
  // A Pause event is recognised by being emitted from the PAUSE state;
  // it neither gets filtered nor updates the held value.
  // ---------------------------------------------------------------------
  logic [8:0] last_make;
  logic       last_valid;
  logic       is_pause_ev;
  logic       same_key;

  assign is_pause_ev = (state == S_PAUSE);
  assign same_key    = last_valid && (last_make == {emit_ext, emit_code});

  always_comb begin
    push_req = emit;
    if (emit && !is_pause_ev && !emit_brk && same_key) begin
      push_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_make  <= '0;
      last_valid <= 1'b0;
    end else if (err_byte) begin
      last_valid <= 1'b0;
    end else if (emit && !is_pause_ev) begin
      if (!emit_brk) begin
        last_make  <= {emit_ext, emit_code};
        last_valid <= 1'b1;
      end else if (same_key) begin
        last_valid <= 1'b0;
      end
    end
  end
`else
  assign push_req = emit;
`endif

  // ---------------------------------------------------------------------
  // Event FIFO. A pop on the same cycle as a push into a full FIFO frees
  // the slot, so both go through and the count stays at DEPTH. Pops are
  // qualified by ev_valid, so a push into an empty FIFO always lands.
  // ---------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign do_pop  = ev_valid & ev_ready;
  assign do_push = push_req & (~full | do_pop);

  // Storage carries no reset; ev_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {emit_ext, emit_brk, emit_code};
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ev_valid = (count != '0);
  assign ev_count = count;
  assign ev_data  = ev_valid ? mem[rd_ptr] : 10'd0;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder (DEPTH = 8). Bytes are driven
// on the falling edge and outputs are checked on the falling edge, half a
// cycle after the decoder acts. Typematic expectations follow the
// PS2_DEC_TYPEMATIC_FILTER_EN macro in the same way the design does.

module tb_ps2_scan_decoder;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_err;
  logic [9:0]  ev_data;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_count;
  logic        overflow;

  int tests_run;
  int tests_failed;

  ps2_scan_decoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .ev_data    (ev_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_count   (ev_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; strobes one byte for exactly one cycle.
  // Consecutive calls give back-to-back strobes.
  task automatic applyStimulus(input logic [7:0] b, input logic err);
    byte_in    = b;
    byte_valid = 1'b1;
    byte_err   = err;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
  endtask

  // Checks the head event, then pops it.
  task automatic popEvent(input string tag, input logic [9:0] expected);
    checkOutput({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
    checkOutput(tag, {22'd0, ev_data}, {22'd0, expected});
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    ev_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("rst_valid",    {31'd0, ev_valid}, 32'd0);
    checkOutput("rst_data",     {22'd0, ev_data},  32'd0);
    checkOutput("rst_count",    {28'd0, ev_count}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Make, extended make, break, extended break
    applyStimulus(8'h1C, 1'b0);
    checkOutput("lat_valid", {31'd0, ev_valid}, 32'd1);
    checkOutput("lat_data",  {22'd0, ev_data},  32'h01C);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("seq_count", {28'd0, ev_count}, 32'd4);
    popEvent("seq_ev0", 10'h01C);
    popEvent("seq_ev1", 10'h275);
    popEvent("seq_ev2", 10'h11C);
    popEvent("seq_ev3", 10'h375);
    checkOutput("seq_empty", {31'd0, ev_valid}, 32'd0);

    // Pause: E1 14 77 E1 F0 14 F0 77 yields a single event
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    checkOutput("pause_early", {28'd0, ev_count}, 32'd0);
    applyStimulus(8'h77, 1'b0);
    checkOutput("pause_count", {28'd0, ev_count}, 32'd1);
    popEvent("pause_ev", 10'h0E1);
    applyStimulus(8'h1C, 1'b0);
    popEvent("after_pause", 10'h01C);

    // Error byte abandons an E0 prefix
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h55, 1'b1);
    checkOutput("err_noevent", {28'd0, ev_count}, 32'd0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("err_count", {28'd0, ev_count}, 32'd1);
    popEvent("err_ev", 10'h075);

    // Typematic repeats: 1C 1C 1C F0 1C 1C
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'h1C, 1'b0);
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    checkOutput("typ_count", {28'd0, ev_count}, 32'd3);
    popEvent("typ_ev0", 10'h01C);
    popEvent("typ_ev1", 10'h11C);
    popEvent("typ_ev2", 10'h01C);
`else
    checkOutput("typ_count", {28'd0, ev_count}, 32'd5);
    popEvent("typ_ev0", 10'h01C);
    popEvent("typ_ev1", 10'h01C);
    popEvent("typ_ev2", 10'h01C);
    popEvent("typ_ev3", 10'h11C);
    popEvent("typ_ev4", 10'h01C);
`endif
    checkOutput("typ_empty", {31'd0, ev_valid}, 32'd0);

    // Overflow: DEPTH+2 distinct make codes with no pops
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b0);
    end
    checkOutput("ovf_count", {28'd0, ev_count}, DEPTH);
    checkOutput("ovf_flag",  {31'd0, overflow}, 32'd1);
    checkOutput("ovf_head",  {22'd0, ev_data},  32'h010);

    // Push and pop together while full
    ev_ready = 1'b1;
    applyStimulus(8'h30, 1'b0);
    ev_ready = 1'b0;
    checkOutput("pp_count", {28'd0, ev_count}, DEPTH);
    checkOutput("pp_flag",  {31'd0, overflow}, 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      popEvent($sformatf("drain%0d", i), 10'h010 + 10'(i));
    end
    popEvent("drain_last", 10'h030);
    checkOutput("drain_empty", {28'd0, ev_count}, 32'd0);

    // Reset in the middle of E0 F0, with an event queued and overflow set
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_valid",    {31'd0, ev_valid}, 32'd0);
    checkOutput("mrst_data",     {22'd0, ev_data},  32'd0);
    checkOutput("mrst_count",    {28'd0, ev_count}, 32'd0);
    checkOutput("mrst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    applyStimulus(8'h75, 1'b0);
    checkOutput("mrst_evcount", {28'd0, ev_count}, 32'd1);
    popEvent("mrst_ev", 10'h075);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
